// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment rule applied before any memory access.
package lsu_pkg;

  localparam int ADDR_W      = 9;
  localparam int WORD_ADDR_W = 7;
  localparam int DATA_W      = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    ERR    = 3'd4,
    RESP   = 3'd5
  } state_e;

  // An illegal size counts as misaligned so it takes the same error path.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load value from a memory
// word, and merges sub-word store data into the old word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        lane_i,
  input  size_e             size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load path: pick the addressed lane, then sign- or zero-extend it.
  always_comb begin
    case (lane_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      default: byte_s = word_i[31:24];
    endcase
    if (lane_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & byte_s[7]}}, byte_s};
      SZ_HALF: load_o = {{16{signed_i & half_s[15]}}, half_s};
      SZ_WORD: load_o = word_i;
      default: load_o = 32'd0;
    endcase
  end

  // Store path: overwrite only the targeted lane(s) of the old word.
  always_comb begin
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane_i[1]) begin
          merge_o[31:16] = wdata_i[15:0];
        end else begin
          merge_o[15:0]  = wdata_i[15:0];
        end
      end
      SZ_WORD: merge_o = wdata_i;
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a 128x32 word memory: one request at a time,
// sub-word stores by read-modify-write, single-cycle registered response.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wd,
  input  logic [DATA_W-1:0]      mem_rd
);

  state_e              state_q;
  size_e               size_q;
  logic                signed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [DATA_W-1:0]   load_s;
  logic [DATA_W-1:0]   merge_s;

  lsu_lane_align u_align (
    .word_i   (mem_rd),
    .wdata_i  (data_q),
    .lane_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .load_o   (load_s),
    .merge_o  (merge_s)
  );

  // Transaction FSM; data_q holds store data, then the merged word for RMW.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      addr_q      <= 9'd0;
      data_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q   <= size_e'(req_size);
            signed_q <= req_signed;
            addr_q   <= req_addr;
            data_q   <= req_wdata;
            if (is_misaligned(size_e'(req_size), req_addr[1:0])) begin
              state_q <= ERR;
            end else if (!req_we) begin
              state_q <= LOAD;
            end else if (req_size == SZ_WORD) begin
              state_q <= WRITE;
            end else begin
              state_q <= RMW_RD;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_s;
          state_q     <= RESP;
        end
        RMW_RD: begin
          data_q  <= merge_s;
          state_q <= WRITE;
        end
        WRITE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        ERR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          state_q     <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes decode from registered state; reset kills an in-flight write.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_addr  = 7'd0;
    mem_we    = 1'b0;
    mem_wd    = 32'd0;
    if (!reset) begin
      case (state_q)
        LOAD, RMW_RD: mem_addr = addr_q[ADDR_W-1:2];
        WRITE: begin
          mem_addr = addr_q[ADDR_W-1:2];
          mem_we   = 1'b1;
          mem_wd   = data_q;
        end
        default: mem_addr = 7'd0;
      endcase
    end else begin
      mem_addr = 7'd0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-array reference memory predicts every response and
// memory write; a negedge process compares the DUT against it each cycle.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Data memory: word write port, asynchronous read.
  logic [31:0] dmem [128];
  bit          mem_init;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] x;
    x = 32'(i) * 32'h9E3779B9;
    return x ^ 32'h5A5AC3C3;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) dmem[i] <= init_word(i);
    end else if (mem_we) begin
      dmem[mem_addr] <= mem_wd;
    end
  end
  assign mem_rd = dmem[mem_addr];

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] ref_b [512];
  typedef struct { int cyc; logic err; logic [31:0] rdata; } rsp_t;
  typedef struct { int cyc; logic [6:0] addr; logic [31:0] data; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];
  int   busy_until;
  bit   chk_en;
  int   checks;
  int   errors;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  function automatic logic [31:0] model_load(input int sz, input int sg, input int a);
    int     n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(ref_b[a+i]) << (8*i));
    if (sg != 0 && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic model_store(input int sz, input int a, input logic [31:0] wd);
    logic [31:0] t;
    for (int i = 0; i < (1 << sz); i++) begin
      t = wd >> (8*i);
      ref_b[a+i] = t[7:0];
    end
  endtask

  task automatic model_accept(input int we, input int sz, input int sg, input int a,
                              input logic [31:0] wd, input int n);
    bit mis;
    mis = (sz == 3) || ((a % (1 << sz)) != 0);
    if (mis) begin
      rq.push_back('{cyc: n+2, err: 1'b1, rdata: 32'd0});
      busy_until = n + 2;
    end else if (we == 0) begin
      rq.push_back('{cyc: n+2, err: 1'b0, rdata: model_load(sz, sg, a)});
      busy_until = n + 2;
    end else begin
      model_store(sz, a, wd);
      if (sz == 2) begin
        wq.push_back('{cyc: n+1, addr: 7'(a >> 2), data: model_word(a >> 2)});
        rq.push_back('{cyc: n+2, err: 1'b0, rdata: 32'd0});
        busy_until = n + 2;
      end else begin
        wq.push_back('{cyc: n+2, addr: 7'(a >> 2), data: model_word(a >> 2)});
        rq.push_back('{cyc: n+3, err: 1'b0, rdata: 32'd0});
        busy_until = n + 3;
      end
    end
  endtask

  // Per-cycle comparison; cur numbers the cycle so that accept at edge N
  // puts the first post-accept cycle at N+1.
  always @(negedge clk) begin : cmp
    int cur;
    if (chk_en) begin
      cur = cyc + 1;
      if (reset) begin
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
        chk32("rst_mem_wd", mem_wd, 32'd0);
      end else begin
        if (rq.size() > 0 && rq[0].cyc == cur) begin
          chk1("rsp_valid", rsp_valid, 1'b1);
          chk1("rsp_err", rsp_err, rq[0].err);
          chk32("rsp_rdata", rsp_rdata, rq[0].rdata);
          void'(rq.pop_front());
        end else begin
          chk1("rsp_valid_idle", rsp_valid, 1'b0);
        end
        if (wq.size() > 0 && wq[0].cyc == cur) begin
          chk1("mem_we", mem_we, 1'b1);
          chk32("mem_addr", {25'd0, mem_addr}, {25'd0, wq[0].addr});
          chk32("mem_wd", mem_wd, wq[0].data);
          void'(wq.pop_front());
        end else begin
          chk1("mem_we_idle", mem_we, 1'b0);
        end
        chk1("req_ready", req_ready, cur > busy_until);
      end
    end
  end

  // Drive one request (entered #1 after a posedge) and record its expectation.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [8:0] a, input logic [31:0] wd, output int acc);
    int guard;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk1("ready_timeout", req_ready, 1'b1);
      acc = -1;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      model_accept(int'(we), int'(sz), int'(sg), int'(a), wd, acc);
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (cyc + 1 <= busy_until && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [8:0] a, input logic [31:0] wd);
    int acc;
    do_req(we, sz, sg, a, wd, acc);
    req_valid = 1'b0;
    wait_done();
  endtask

  initial begin : stim
    int a1, a2, acc;
    logic [31:0] old_w;
    logic [1:0]  sz;
    logic [8:0]  ad;
    checks = 0; errors = 0; chk_en = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 9'd0; req_wdata = 32'd0;
    reset = 1'b1; mem_init = 1'b1;
    for (int w = 0; w < 128; w++) begin
      old_w = init_word(w);
      for (int b = 0; b < 4; b++) ref_b[4*w+b] = old_w[8*b +: 8];
    end
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_rsp_err", rsp_err, 1'b0);
    chk32("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk1("reset_req_ready", req_ready, 1'b1);
    chk1("reset_mem_we", mem_we, 1'b0);
    reset = 1'b0;
    busy_until = cyc;
    chk_en = 1'b1;

    // Word store then load
    run(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
    chk32("pin_model_w4", model_word(4), 32'hDEADBEEF);
    chk32("mem_w4_store", dmem[4], 32'hDEADBEEF);
    run(1'b0, 2'b10, 1'b0, 9'h010, 32'd0);

    // Byte read-modify-write
    run(1'b1, 2'b00, 1'b0, 9'h012, 32'h000000A5);
    chk32("pin_model_rmw", model_word(4), 32'hDEA5BEEF);
    chk32("mem_w4_rmw", dmem[4], 32'hDEA5BEEF);

    // Extension
    chk32("pin_lb_signed", model_load(0, 1, 9'h013), 32'hFFFFFFDE);
    chk32("pin_lb_unsigned", model_load(0, 0, 9'h013), 32'h000000DE);
    chk32("pin_lh_signed", model_load(1, 1, 9'h010), 32'hFFFFBEEF);
    run(1'b0, 2'b00, 1'b1, 9'h013, 32'd0);
    run(1'b0, 2'b00, 1'b0, 9'h013, 32'd0);
    run(1'b0, 2'b01, 1'b1, 9'h010, 32'd0);

    // Misaligned and illegal
    run(1'b0, 2'b10, 1'b0, 9'h011, 32'd0);
    run(1'b1, 2'b01, 1'b0, 9'h013, 32'h12345678);
    run(1'b1, 2'b11, 1'b0, 9'h010, 32'h12345678);
    chk32("mem_w4_after_err", dmem[4], 32'hDEA5BEEF);

    // Back-to-back with req_valid held high
    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, a1);
    do_req(1'b0, 2'b00, 1'b1, 9'h013, 32'd0, a2);
    req_valid = 1'b0;
    wait_done();
    chk32("b2b_accept_gap", 32'(a2 - a1), 32'd3);

    // Reset during the WRITE cycle of a byte store
    old_w = model_word(4);
    do_req(1'b1, 2'b00, 1'b0, 9'h011, 32'h00000077, acc);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    rq.delete();
    wq.delete();
    for (int b = 0; b < 4; b++) ref_b[16+b] = old_w[8*b +: 8];
    busy_until = cyc + 1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk1("post_reset_ready", req_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk32("mem_w4_after_abort", dmem[4], 32'hDEA5BEEF);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ad = 9'($urandom);
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        if (sz == 2'b10) ad[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), ad, $urandom, acc);
      if ($urandom_range(0, 2) != 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
    end
    req_valid = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk32("rsp_queue_drained", 32'(rq.size()), 32'd0);
    chk32("wr_queue_drained", 32'(wq.size()), 32'd0);
    for (int w = 0; w < 128; w++) chk32("final_mem_word", dmem[w], model_word(w));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
